exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
- Multi-cycle RV32M execute unit, parametrised in data width and multiply latency.
- Sits beside the combinational ALU in the execute stage and services opcode 0110011 with funct7[0]=1 (M_TYPE).
- Holds the pipeline with stallreq_o until the result is ready, then presents a one-cycle write-back.
- Multiply is pipelined/delayed by a fixed latency; divide/remainder use an iterative restoring divider, one quotient bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >=8.
- RADDR_WIDTH, 5, destination register address width.
- MUL_LATENCY, 2, cycles from acceptance to multiply result; must be >=1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  M-type instruction present in execute; held high by the stall until completion.
- funct3_i  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  DATA_WIDTH  rs1 value.
- op2_i  in  DATA_WIDTH  rs2 value.
- reg_waddr_i  in  RADDR_WIDTH  destination register.
- flush_i  in  1  jump/branch kill; abandons any operation in flight.
- busy_o  out  1  state is MUL or DIV.
- stallreq_o  out  1  combinational: start_i & (state != DONE) & ~flush_i.
- valid_o  out  1  one-cycle result pulse.
- result_o  out  DATA_WIDTH  result; valid when valid_o=1, otherwise holds its last value.
- reg_we_o  out  1  equals valid_o.
- reg_waddr_o  out  RADDR_WIDTH  destination latched at acceptance.

Behaviour:
- Reset, applied synchronously whenever rst_i=1 regardless of state: state=IDLE; busy_o, valid_o, reg_we_o=0; result_o=0; reg_waddr_o=0.
- States:
  - IDLE: start_i=1 and flush_i=0 accepts the op (cycle T). Latches funct3_i, op1_i, op2_i and reg_waddr_i.
    - funct3[2]=0: goes to MUL.
    - funct3[2]=1 with divisor zero or signed overflow: goes directly to DONE.
    - Otherwise goes to DIV.
  - MUL: counts MUL_LATENCY-1 cycles, then moves to DONE.
    - Product width is 2*DATA_WIDTH.
    - MUL returns the low half. MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - DIV: DATA_WIDTH iterations on operand magnitudes (signed ops) or raw values (unsigned ops), then moves to DONE.
    - Sign fixup on the DONE transition: quotient sign = sign(op1) xor sign(op2); remainder sign = sign(op1).
  - DONE: valid_o=1, result_o driven, stallreq_o=0 so the pipeline advances; moves to IDLE next cycle unconditionally.
    - start_i seen in DONE is the completing instruction and is not re-accepted.
    - A new op is accepted no earlier than the cycle after DONE.
- Latency, where T is the acceptance cycle:
  - valid_o high in cycle T+MUL_LATENCY for MUL*.
  - valid_o high in cycle T+DATA_WIDTH+1 for DIV/REM in the normal case.
  - valid_o high in cycle T+1 for special cases.
- Special cases (RISC-V defined):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op1.
  - Signed overflow (op1 = most-negative, op2 = -1): DIV = op1; REM = 0.
- stallreq_o is high during cycles T .. valid-1.
- flush_i=1 in any state: next state IDLE, no valid_o, no register write; a start_i in the same cycle is not accepted.
- start_i deasserted mid-operation (flush without flush_i): the operation completes and still pulses valid_o.
- Arithmetic is modulo 2^DATA_WIDTH; no exceptions or traps.

Test Plan:
- MUL 7×(-3), MUL_LATENCY=2 -> valid_o at T+2, result 0xFFFFFFEB, reg_waddr_o echoes 5'd10, stallreq_o high exactly cycles T..T+1.
- MULH/MULHSU/MULHU with 0x80000000×0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV -20/3 -> -6 (0xFFFFFFFA); REM -20/3 -> -2 (0xFFFFFFFE); valid_o at T+33; DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero, DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5. Overflow DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- flush_i asserted at T+10 during DIV -> IDLE next cycle, no valid_o. Next DIVU 9/2 accepted and returns 4 at its own T+33.
- rst_i pulsed mid-MUL -> all outputs 0 next cycle. Back-to-back MUL then DIV -> second op accepted the cycle after the first valid_o, and both results correct.

Source files
------------

// File: rtl/exe_muldiv.sv
// RV32M multiply/divide execute unit: fixed-latency multiply, restoring divider
// (one quotient bit per cycle), pipeline stall until a one-cycle write-back.
module exe_muldiv #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2:0]             funct3_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   stallreq_o,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

    localparam int unsigned W        = DATA_WIDTH;
    localparam int unsigned PW       = 2 * DATA_WIDTH;
    localparam int unsigned CNT_MAX  = (W > MUL_LATENCY) ? W : MUL_LATENCY;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
    localparam int unsigned DIV_LAST = W - 1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             f3_q, f3_d;
    logic [W-1:0]           opa_q, opa_d;
    logic [W-1:0]           opb_q, opb_d;
    logic [W-1:0]           rem_q, rem_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic [W-1:0]           result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;

    // Acceptance-time operand decode for the divider
    logic         in_signed;
    logic         op1_neg, op2_neg;
    logic [W-1:0] op1_mag, op2_mag;
    logic         div_zero, div_ovf;

    always_comb begin
        in_signed = ~funct3_i[0];
        op1_neg   = in_signed & op1_i[W-1];
        op2_neg   = in_signed & op2_i[W-1];
        op1_mag   = op1_neg ? (W'(0) - op1_i) : op1_i;
        op2_mag   = op2_neg ? (W'(0) - op2_i) : op2_i;
        div_zero  = (op2_i == {W{1'b0}});
        div_ovf   = in_signed & (op1_i == MOST_NEG) & (op2_i == {W{1'b1}});
    end

    // Multiplier reads the live inputs in IDLE so a latency of one still works
    logic [W-1:0]  mul_a, mul_b;
    logic [1:0]    mul_f3;
    logic [PW-1:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [W-1:0]  mul_res;

    always_comb begin
        mul_a     = (state_q == S_IDLE) ? op1_i : opa_q;
        mul_b     = (state_q == S_IDLE) ? op2_i : opb_q;
        mul_f3    = (state_q == S_IDLE) ? funct3_i[1:0] : f3_q;
        mul_a_ext = ((mul_f3 != 2'b11) && mul_a[W-1]) ? {{W{1'b1}}, mul_a} : {{W{1'b0}}, mul_a};
        mul_b_ext = ((mul_f3 == 2'b01) && mul_b[W-1]) ? {{W{1'b1}}, mul_b} : {{W{1'b0}}, mul_b};
        mul_prod  = mul_a_ext * mul_b_ext;
        mul_res   = (mul_f3 == 2'b00) ? mul_prod[W-1:0] : mul_prod[PW-1:W];
    end

    // One restoring step: opa_q shifts dividend bits out and quotient bits in
    logic [W:0]   rem_sh, rem_diff;
    logic         take;
    logic [W-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    always_comb begin
        rem_sh   = {rem_q, opa_q[W-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        take     = ~rem_diff[W];
        rem_nx   = take ? rem_diff[W-1:0] : rem_sh[W-1:0];
        quo_nx   = {opa_q[W-2:0], take};
        quo_fix  = q_neg_q ? (W'(0) - quo_nx) : quo_nx;
        rem_fix  = r_neg_q ? (W'(0) - rem_nx) : rem_nx;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        f3_d    = funct3_i[1:0];
                        waddr_d = reg_waddr_i;
                        cnt_d   = '0;
                        if (!funct3_i[2]) begin
                            opa_d = op1_i;
                            opb_d = op2_i;
                            if (MUL_LATENCY == 1) begin
                                state_d  = S_DONE;
                                valid_d  = 1'b1;
                                result_d = mul_res;
                            end else begin
                                state_d = S_MUL;
                            end
                        end else if (div_zero) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            result_d = funct3_i[1] ? op1_i : {W{1'b1}};
                        end else if (div_ovf) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            result_d = funct3_i[1] ? {W{1'b0}} : op1_i;
                        end else begin
                            opa_d   = op1_mag;
                            opb_d   = op2_mag;
                            rem_d   = '0;
                            q_neg_d = op1_neg ^ op2_neg;
                            r_neg_d = op1_neg;
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_W'(MUL_LAST)) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = mul_res;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    opa_d = quo_nx;
                    rem_d = rem_nx;
                    if (cnt_q == CNT_W'(DIV_LAST)) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = f3_q[1] ? rem_fix : quo_fix;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            waddr_q  <= waddr_d;
        end
    end

    assign stallreq_o  = start_i & (state_q != S_DONE) & ~flush_i;
    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign reg_we_o    = valid_q;
    assign result_o    = result_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: driver queues expected write-backs, a
// negedge monitor pops and compares result, destination and arrival cycle.
module tb_exe_muldiv;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned ML = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [2:0]    funct3_i = '0;
    logic [DW-1:0] op1_i = '0;
    logic [DW-1:0] op2_i = '0;
    logic [AW-1:0] reg_waddr_i = '0;
    logic          flush_i = 1'b0;
    logic          busy_o, stallreq_o, valid_o, reg_we_o;
    logic [DW-1:0] result_o;
    logic [AW-1:0] reg_waddr_o;

    exe_muldiv #(.DATA_WIDTH(DW), .RADDR_WIDTH(AW), .MUL_LATENCY(ML)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .funct3_i    (funct3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .stallreq_o  (stallreq_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  wa;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation
    exp_t e;
    always @(negedge clk_i) begin
        if (valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1'b0, result_o, 32'h0);
            end else begin
                e = sb.pop_front();
                check({e.tag, " result"}, result_o === e.res, result_o, e.res);
                check({e.tag, " waddr"}, reg_waddr_o === e.wa && reg_we_o === 1'b1,
                      32'(reg_waddr_o), 32'(e.wa));
                check({e.tag, " cycle"}, cyc == e.cyc, cyc, e.cyc);
            end
        end
    end

    // Issue one op, hold start through the stall, count stalled cycles
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp_res,
                          input int lat, input bit keep);
        int t;
        int stalls;
        bit got;
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b; reg_waddr_i = wa;
        t = cyc;
        sb.push_back('{tag, exp_res, wa, t + lat});
        stalls = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (stallreq_o) stalls++;
            if (valid_o) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " stall"}, got && stalls == lat, stalls, lat);
        if (!keep) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset valid", valid_o === 1'b0 && reg_we_o === 1'b0, 32'(valid_o), 32'h0);
        check("reset busy", busy_o === 1'b0, 32'(busy_o), 32'h0);
        check("reset result", result_o === 32'h0, result_o, 32'h0);
        check("reset waddr", reg_waddr_o === 5'd0, 32'(reg_waddr_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 2, 1'b0);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 2, 1'b0);
        run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, 1'b0);
        run_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h7FFF_FFFF, 2, 1'b0);

        run_op("div",    3'b100, 32'hFFFF_FFEC, 32'd3,        5'd14, 32'hFFFF_FFFA, 33, 1'b0);
        run_op("rem",    3'b110, 32'hFFFF_FFEC, 32'd3,        5'd15, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("divu",   3'b101, 32'd100,       32'd7,        5'd16, 32'd14,        33, 1'b0);
        run_op("remu",   3'b111, 32'd100,       32'd7,        5'd17, 32'd2,         33, 1'b0);
        run_op("div_nd", 3'b100, 32'd20,        32'hFFFF_FFFD, 5'd18, 32'hFFFF_FFFA, 33, 1'b0);
        run_op("rem_nd", 3'b110, 32'd20,        32'hFFFF_FFFD, 5'd19, 32'd2,         33, 1'b0);
        run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,       33, 1'b0);
        run_op("remu_big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 33, 1'b0);

        run_op("div_z",  3'b100, 32'd5, 32'd0, 5'd22, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_z", 3'b111, 32'd5, 32'd0, 5'd23, 32'd5,         1, 1'b0);
        run_op("divu_z", 3'b101, 32'd5, 32'd0, 5'd24, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem_z",  3'b110, 32'd5, 32'd0, 5'd25, 32'd5,         1, 1'b0);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 32'h8000_0000, 1, 1'b0);
        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 32'd0,         1, 1'b0);

        // Flush ten cycles into a divide: nothing may be written back
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = 3'b100; op1_i = 32'd1000; op2_i = 32'd7; reg_waddr_i = 5'd3;
        repeat (10) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(negedge clk_i);
        check("flush stallreq", stallreq_o === 1'b0, 32'(stallreq_o), 32'h0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("flush busy", busy_o === 1'b0, 32'(busy_o), 32'h0);
        nv = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) nv++;
        end
        check("flush no_valid", nv == 0, nv, 0);
        run_op("divu_post", 3'b101, 32'd9, 32'd2, 5'd4, 32'd4, 33, 1'b0);

        // Synchronous reset in the middle of a multiply
        @(posedge clk_i); #1;
        start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd3; op2_i = 32'd4; reg_waddr_i = 5'd7;
        @(posedge clk_i); #1;
        rst_i = 1'b1; start_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst valid", valid_o === 1'b0 && reg_we_o === 1'b0, 32'(valid_o), 32'h0);
        check("midrst busy", busy_o === 1'b0, 32'(busy_o), 32'h0);
        check("midrst result", result_o === 32'h0, result_o, 32'h0);
        check("midrst waddr", reg_waddr_o === 5'd0, 32'(reg_waddr_o), 32'h0);
        repeat (5) @(negedge clk_i);

        // Back-to-back: divide issued in the cycle right after the multiply write-back
        run_op("b2b_mul", 3'b000, 32'd6,   32'd7,        5'd8, 32'd42,        2,  1'b1);
        run_op("b2b_div", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 33, 1'b0);

        repeat (5) @(negedge clk_i);
        check("scoreboard drained", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
